// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_e       : FSM states (IDLE, XFER, RESP)
//   REQ_IF/REQ_D  : requester IDs (instruction fetch / data)
//   SIZE_*        : size encodings, byte count N = size + 1
//   byte_lane()   : index of the wdata byte driven in transfer cycle k
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_3B = 2'd2;
  localparam logic [1:0] SIZE_4B = 2'd3;

  // Big-endian: cycle k carries byte (N-1-k) of the word, which is size-k.
  function automatic logic [1:0] byte_lane(input logic [1:0] size, input logic [1:0] k);
    return size - k;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter with last-served record.
//   clock, reset      : clock and synchronous active-high reset
//   req_if_i, req_d_i : request lines of the two requesters
//   accept_i          : a grant was taken this cycle; update last-served
//   gnt_if_o, gnt_d_o : one-hot (or zero) grant
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_if_i,
  input  logic req_d_i,
  input  logic accept_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);

  logic last_q;

  // NOTE: every output of a combinational block gets a default first so
  // no path through it can leave a value held, which would infer a latch.
  always_comb begin
    gnt_if_o = 1'b0;
    gnt_d_o  = 1'b0;
    if (req_d_i && (!req_if_i || last_q == REQ_IF)) begin
      gnt_d_o = 1'b1;
    end else if (req_if_i) begin
      gnt_if_o = 1'b1;
    end
  end

  // Last-served starts at instruction so data wins the first tie.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= REQ_IF;
    end else if (accept_i) begin
      last_q <= gnt_d_o ? REQ_D : REQ_IF;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one
// single-ported byte memory; multi-byte accesses are serialised one byte
// per cycle, big-endian.
//   clock, reset                        : clock, synchronous active-high reset
//   if_valid/if_ready/if_addr/if_size   : fetch request (read only)
//   if_rvalid/if_rdata                  : fetch response
//   d_valid/d_ready/d_addr/d_size/
//   d_we/d_wdata                        : data request
//   d_rvalid/d_rdata                    : data response
//   mem_addr/mem_we/mem_wdata/mem_rdata : byte memory (read is combinational)
//   busy                                : high whenever not IDLE
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [1:0]         size_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic               id_q;
  logic [1:0]         k_q;
  logic [31:0]        acc_q;
  logic [31:0]        acc_d;
  logic [31:0]        if_rdata_q;
  logic [31:0]        d_rdata_q;

  logic gnt_if, gnt_d, accept, idle, xfer;
  logic [1:0] lane;

  assign idle = (state_q == IDLE);
  assign xfer = (state_q == XFER);

  arb_rr2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_if_i (if_valid),
    .req_d_i  (d_valid),
    .accept_i (accept),
    .gnt_if_o (gnt_if),
    .gnt_d_o  (gnt_d)
  );

  // Ready is masked by reset so a reset edge never doubles as an acceptance.
  assign if_ready = idle && gnt_if && !reset;
  assign d_ready  = idle && gnt_d && !reset;
  assign accept   = if_ready || d_ready;

  assign lane      = byte_lane(size_q, k_q);
  assign acc_d     = {acc_q[23:0], mem_rdata};
  assign mem_addr  = xfer ? base_q + ADDR_W'(k_q) : '0;
  // Reset suppresses the in-flight byte so an aborted write stops at once.
  assign mem_we    = xfer && we_q && !reset;
  assign mem_wdata = (xfer && we_q) ? wdata_q[{lane, 3'b000} +: 8] : 8'h00;

  assign if_rvalid = (state_q == RESP) && (id_q == REQ_IF);
  assign d_rvalid  = (state_q == RESP) && (id_q == REQ_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = !idle;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      size_q     <= SIZE_1B;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      id_q       <= REQ_IF;
      k_q        <= '0;
      acc_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q  <= d_ready ? d_addr : if_addr;
            size_q  <= d_ready ? d_size : if_size;
            we_q    <= d_ready && d_we;
            wdata_q <= d_ready ? d_wdata : 32'h0;
            id_q    <= d_ready ? REQ_D : REQ_IF;
            k_q     <= '0;
            acc_q   <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          acc_q <= acc_d;
          if (k_q == size_q) begin
            state_q <= RESP;
            if (id_q == REQ_D) begin
              d_rdata_q <= we_q ? 32'h0 : acc_d;
            end else begin
              if_rdata_q <= acc_d;
            end
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        RESP: begin
          k_q     <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: stimulus pushes expected memory
// accesses and responses; negedge monitors pop and compare.
module tb_memory_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } acc_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic        clock;
  logic        reset;
  logic        if_valid, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic [1:0]  if_size;
  logic        d_valid, d_ready, d_we, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];
  logic  grant_log[$];

  // Byte memory model: 16 bytes indexed by addr[3:0]; 0xFFFFFFFF maps to 15.
  logic [7:0] mem [16] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEE};

  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clock) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

  memory_port_arbiter #(.ADDR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_addr   (if_addr),
    .if_size   (if_size),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_addr    (d_addr),
    .d_size    (d_size),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request, wait (bounded) for acceptance, push expectations.
  task automatic issue(input logic is_d, input logic [31:0] addr, input logic [1:0] size,
                       input logic we, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit push_exp);
    bit got = 0;
    int c;
    if (is_d) begin
      d_valid = 1'b1; d_addr = addr; d_size = size; d_we = we; d_wdata = wdata;
    end else begin
      if_valid = 1'b1; if_addr = addr; if_size = size;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = is_d ? d_ready : if_ready;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: requester %0d addr %0h never accepted", is_d, addr);
      if (is_d) d_valid = 1'b0; else if_valid = 1'b0;
      return;
    end
    c = cyc;
    grant_log.push_back(is_d);
    if (push_exp) begin
      for (int k = 0; k <= int'(size); k++) begin
        acc_t a;
        a.addr  = addr + 32'(k);
        a.we    = we;
        a.wdata = 8'(wdata >> (8 * (int'(size) - k)));
        exp_acc.push_back(a);
      end
      begin
        resp_t r;
        r.is_d = is_d;
        r.data = exp_rdata;
        r.due  = c + int'(size) + 2;
        exp_resp.push_back(r);
      end
    end
    @(posedge clock);
    #1;
    if (is_d) d_valid = 1'b0; else if_valid = 1'b0;
  endtask

  // Memory-side monitor: an XFER cycle shows busy without a response pulse.
  always @(negedge clock) begin
    if (busy) check("ready_outside_idle", 64'({if_ready, d_ready}), 64'(2'b00));
    if (busy && !if_rvalid && !d_rvalid) begin
      if (exp_acc.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_access: unexpected access addr %0h we %0b", mem_addr, mem_we);
      end else begin
        acc_t a;
        a = exp_acc.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(a.addr));
        check("mem_we", 64'(mem_we), 64'(a.we));
        if (a.we) check("mem_wdata", 64'(mem_wdata), 64'(a.wdata));
      end
    end else begin
      check("mem_idle", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
    end
  end

  // Response monitor.
  always @(negedge clock) begin
    if (if_rvalid || d_rvalid) begin
      if (exp_resp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rvalid: unexpected response if=%0b d=%0b", if_rvalid, d_rvalid);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        check("rvalid_port", 64'({if_rvalid, d_rvalid}), r.is_d ? 64'(2'b01) : 64'(2'b10));
        check("rdata", r.is_d ? 64'(d_rdata) : 64'(if_rdata), 64'(r.data));
        check("rvalid_cycle", 64'(cyc), 64'(r.due));
      end
    end
  end

  initial begin
    logic exp_g [4];
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    if_valid = 1'b0; if_addr = '0; if_size = '0;
    d_valid = 1'b0; d_addr = '0; d_size = '0; d_we = 1'b0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state.
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'(0));
    check("rst_if_rdata", 64'(if_rdata), 64'(0));
    check("rst_d_rdata", 64'(d_rdata), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));

    // Both requesters valid from reset: D, IF, D, IF.
    grant_log.delete();
    @(posedge clock);
    #1;
    fork
      begin
        issue(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0000_0010, 1'b1);
        issue(1'b0, 32'h1, 2'd0, 1'b0, 32'h0, 32'h0000_0020, 1'b1);
      end
      begin
        issue(1'b1, 32'h2, 2'd0, 1'b0, 32'h0, 32'h0000_0030, 1'b1);
        issue(1'b1, 32'h3, 2'd0, 1'b0, 32'h0, 32'h0000_0040, 1'b1);
      end
      begin
        @(posedge clock);
        #1 reset = 1'b0;
      end
    join
    check("grant_count", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("grant_order", 64'(grant_log[i]), 64'(exp_g[i]));

    // 4-byte big-endian fetch.
    issue(1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 32'h1020_3040, 1'b1);
    // 2-byte write: AB@4, CD@5, zero response.
    issue(1'b1, 32'h4, 2'd1, 1'b1, 32'h0000_ABCD, 32'h0, 1'b1);
    // Address wrap: FFFFFFFF then 00000000.
    issue(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0, 32'h0000_EE10, 1'b1);
    // Single byte write then read back.
    issue(1'b1, 32'h2, 2'd0, 1'b1, 32'h0000_007F, 32'h0, 1'b1);
    issue(1'b0, 32'h2, 2'd0, 1'b0, 32'h0, 32'h0000_007F, 1'b1);
    repeat (6) @(posedge clock);
    #1;

    // Reset during the 2nd XFER cycle of a 4-byte write.
    exp_acc.push_back('{addr: 32'h8, we: 1'b1, wdata: 8'h11});
    exp_acc.push_back('{addr: 32'h9, we: 1'b0, wdata: 8'h22});
    issue(1'b1, 32'h8, 2'd3, 1'b1, 32'h1122_3344, 32'h0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rvalid", 64'({if_rvalid, d_rvalid}), 64'(0));
    check("abort_if_rdata", 64'(if_rdata), 64'(0));
    check("abort_mem8", 64'(mem[8]), 64'(8'h11));
    check("abort_mem9", 64'(mem[9]), 64'(8'h00));
    repeat (5) @(posedge clock);
    #1;
    issue(1'b0, 32'h8, 2'd1, 1'b0, 32'h0, 32'h0000_1100, 1'b1);

    // Drain, bounded.
    for (int i = 0; i < 20 && (exp_resp.size() != 0 || exp_acc.size() != 0); i++)
      @(negedge clock);
    repeat (2) @(negedge clock);
    check("resp_drained", 64'(exp_resp.size()), 64'(0));
    check("acc_drained", 64'(exp_acc.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
